// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch FSM states and fetch defaults
package cpu_pkg;

    localparam int BUS_W         = 16;
    localparam int ADDR_W_DEF    = 16;
    localparam int CNT_W_DEF     = 16;
    localparam int MAX_RETRY_DEF = 3;
    localparam int RETRY_W       = 4;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_FULL  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with stale drop, retry and fault
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = BUS_W,
    parameter int MAX_RETRY = MAX_RETRY_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              ir_ack,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              fetch_fault,
    output logic [CNT_W-1:0]  fetch_cnt
);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [ADDR_W-1:0]   req_addr;
    logic [RETRY_W-1:0]  retry_cnt;
    logic                addr_match;
    logic                load_addr;
    logic                retry_inc;
    logic                load_ir;

    assign addr_match = (req_addr == pc_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stale check comes before the error check so a moved PC never burns a retry.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        retry_inc  = 1'b0;
        load_ir    = 1'b0;
        case (state)
            FS_IDLE: begin
                if (enable) begin
                    load_addr  = 1'b1;
                    state_next = FS_REQ;
                end
            end
            FS_REQ: begin
                if (mem_gnt) begin
                    state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (mem_rvalid) begin
                    if (!addr_match) begin
                        load_addr  = 1'b1;
                        state_next = FS_REQ;
                    end else if (!mem_err) begin
                        load_ir    = 1'b1;
                        state_next = FS_FULL;
                    end else if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
                        state_next = FS_FAULT;
                    end else begin
                        retry_inc  = 1'b1;
                        state_next = FS_REQ;
                    end
                end
            end
            FS_FULL: begin
                if (ir_ack) begin
                    state_next = FS_IDLE;
                end else if (!addr_match) begin
                    load_addr  = 1'b1;
                    state_next = FS_REQ;
                end
            end
            FS_FAULT: begin
                state_next = FS_FAULT;
            end
            default: begin
                state_next = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr  <= '0;
            retry_cnt <= '0;
            ir_out    <= '0;
            fetch_cnt <= '0;
        end else begin
            if (load_addr) begin
                req_addr  <= pc_in;
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
            if (load_ir) begin
                ir_out    <= mem_rdata;
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    // Handshake outputs decode straight from registers, so they are glitch-free and clear with reset.
    assign mem_req     = (state == FS_REQ);
    assign mem_addr    = req_addr;
    assign ir_valid    = (state == FS_FULL);
    assign fetch_fault = (state == FS_FAULT);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sits directly upstream of the CPU controller.
- Takes the controller's PC output, issues single-outstanding read requests to instruction memory over a req/gnt/rvalid handshake, and holds the returned word.
- Presents the held word as IR to the controller until the controller loads it (IL pulse, exported as ir_ack).
- Drops stale responses when PC changes, retries on memory error, and enters a sticky fault after MAX_RETRY consecutive errors.

Parameters:
- ADDR_W, 16, width of PC / memory address.
- DATA_W, 16, instruction width (equals controller busSize).
- MAX_RETRY, 3, consecutive mem_err responses on one address before fault; legal range 1..15.
- CNT_W, 16, width of the fetch_cnt performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows a new fetch to launch from IDLE.
- pc_in  in  ADDR_W  current PC from controller.
- ir_ack  in  1  controller has loaded IR this cycle (IL).
- ir_out  out  DATA_W  held instruction word to controller IR input.
- ir_valid  out  1  ir_out valid and matches pc_in.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  request address.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response valid.
- mem_rdata  in  DATA_W  response data.
- mem_err  in  1  response is an error (qualified by mem_rvalid).
- fetch_fault  out  1  sticky fault flag.
- fetch_cnt  out  CNT_W  count of successful fetches; wraps.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - ir_out=0, ir_valid=0, mem_req=0, mem_addr=0.
  - fetch_fault=0, fetch_cnt=0, retry_cnt=0, req_addr=0.
  - A reset mid-transaction abandons it; any later mem_rvalid is ignored because state≠WAIT.
- States: IDLE, REQ, WAIT, FULL, FAULT (encoded in the package).
- IDLE:
  - If enable=1: req_addr<=pc_in, retry_cnt<=0, go to REQ.
  - Otherwise stay.
- REQ:
  - mem_req=1, mem_addr=req_addr (both registered from req_addr/state; stable until gnt).
  - On mem_gnt=1, go to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1 with mem_err=0 and req_addr==pc_in:
    - ir_out<=mem_rdata, fetch_cnt<=fetch_cnt+1 (mod 2^CNT_W), go to FULL.
  - On mem_rvalid=1 with req_addr!=pc_in (stale, checked before mem_err):
    - Discard the response; req_addr<=pc_in, retry_cnt<=0, go to REQ.
  - On mem_rvalid=1 with mem_err=1 and addresses matching:
    - If retry_cnt==MAX_RETRY-1: go to FAULT.
    - Else: retry_cnt++, go to REQ with the same req_addr.
- FULL:
  - ir_valid=1 (registered, first high the cycle after the accepted rvalid).
  - ir_ack=1: ir_valid<=0, go to IDLE. ir_out keeps its value. The IDLE cycle lets the controller's PC settle.
  - ir_ack=0 and pc_in!=req_addr (branch without load): ir_valid<=0, req_addr<=pc_in, go to REQ.
  - ir_ack and PC mismatch in the same cycle: ack wins (go to IDLE).
- FAULT:
  - fetch_fault=1, all requests stop, ir_valid=0.
  - Exit only by reset.
- Other rules:
  - enable is sampled only in IDLE; deasserting it never aborts an in-flight request.
  - mem_rvalid outside WAIT is ignored.
  - Memory contract: at most one outstanding request; responses in order.
- Minimum latency: enable at cycle 0 (IDLE), REQ at cycle 1 with gnt, rvalid at cycle 2, ir_valid=1 at cycle 3. Back-to-back fetch period ≥4 cycles.

Decomposition:
- Shared cpu_pkg holds:
  - bus/address widths (16), shared with the controller;
  - the fetch state enum;
  - the MAX_RETRY default.
- No sub-module is natural: one FSM plus a datapath of holding register, address register and counters, ~150–200 lines.

Test Plan:
- Basic fetch: reset release, enable=1, pc_in=0x0010, gnt in REQ cycle 1, rvalid with rdata=0xA5C3 in cycle 2 -> mem_addr=0x0010 while mem_req=1; ir_valid=1 and ir_out=0xA5C3 at cycle 3; fetch_cnt=1.
- Ack and next fetch: in FULL, pulse ir_ack, then pc_in=0x0011 -> IDLE for one cycle, then mem_req with mem_addr=0x0011; ir_valid low until new data arrives.
- Stale drop: in WAIT change pc_in 0x0020->0x0040, return rvalid with rdata=0x1111 -> data discarded, new mem_req with mem_addr=0x0040; fetch_cnt unchanged; next rdata=0x2222 appears on ir_out.
- Error retry and fault (MAX_RETRY=3): two mem_err responses then good data 0x3333 -> two re-requests to the same address, ir_out=0x3333, fetch_fault=0. Three consecutive errors -> fetch_fault=1 sticky, mem_req stays 0 despite enable=1, cleared only by reset.
- Branch in FULL: ir_valid=1 at pc_in=0x0050, then pc_in=0x0080 with ir_ack=0 -> ir_valid=0 next cycle, mem_addr=0x0080. Repeat with ir_ack=1 in the same cycle -> IDLE (ack wins).
- Async reset mid-WAIT: assert reset between gnt and rvalid -> all outputs 0 immediately; rvalid arriving after release is ignored; fetch_cnt=0.
